// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Multi-cycle MEM-stage access controller driving an SRAM-like
//   request/response bus (req / addr_ok / data_ok). Performs byte-lane
//   steering, write-strobe generation, load sign/zero extension and
//   alignment-exception detection. Keeps the pipeline stalled while a
//   transaction is outstanding and drains accepted transactions on flush.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   valid_i, we_i, size_i     access request: valid, store/load, size (0..3)
//   sext_i                    sign-extend load result
//   addr_i, wdata_i           byte address, right-aligned store data
//   exc_i, flush_i            earlier exception pending, pipeline flush
//   stall_o, done_o           hold pipeline, one-cycle completion pulse
//   rdata_o                   extended load result (held until next load)
//   adel_o, ades_o            load / store address-error flags
//   bus_req_o .. bus_wdata_o  registered bus request fields
//   bus_addr_ok_i             request accepted this cycle
//   bus_data_ok_i             read data valid / write completed
//   bus_rdata_i               raw read data
module mem_access_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic                  we_i,
    input  logic [1:0]            size_i,
    input  logic                  sext_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic                  exc_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  adel_o,
    output logic                  ades_o,
    output logic                  bus_req_o,
    output logic                  bus_wr_o,
    output logic [1:0]            bus_size_o,
    output logic [ADDR_W-1:0]     bus_addr_o,
    output logic [DATA_W/8-1:0]   bus_wstrb_o,
    output logic [DATA_W-1:0]     bus_wdata_o,
    input  logic                  bus_addr_ok_i,
    input  logic                  bus_data_ok_i,
    input  logic [DATA_W-1:0]     bus_rdata_i
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_next_s;

    logic [LANE_W-1:0]   lane_s;
    logic                misaligned_s;
    logic                legal_s;
    int                  lane_int_s;
    int                  nbytes_s;
    logic [STRB_W-1:0]   wstrb_s;
    logic [DATA_W-1:0]   wdata_rep_s;

    logic                bus_req_r;
    logic                done_r;
    logic [DATA_W-1:0]   rdata_r;
    logic                bus_wr_r;
    logic [1:0]          bus_size_r;
    logic [ADDR_W-1:0]   bus_addr_r;
    logic [STRB_W-1:0]   bus_wstrb_r;
    logic [DATA_W-1:0]   bus_wdata_r;
    logic                sext_r;
    logic [LANE_W-1:0]   lane_r;

    logic [DATA_W-1:0]   shifted_s;
    logic [DATA_W-1:0]   load_ext_s;
    logic                sign_bit_s;
    int                  nbits_s;

    assign lane_s     = addr_i[LANE_W-1:0];
    assign lane_int_s = int'(lane_s);
    assign nbytes_s   = int'(32'd1 << size_i);

    // Alignment check; a dword access on a 32-bit bus is always illegal.
    always_comb begin
        misaligned_s = 1'b0;
        case (size_i)
            2'd0:    misaligned_s = 1'b0;
            2'd1:    misaligned_s = lane_s[0];
            2'd2:    misaligned_s = (lane_s[1:0] != 2'b00);
            2'd3:    misaligned_s = (DATA_W == 32'sd32) ? 1'b1 : (lane_s != {LANE_W{1'b0}});
            default: misaligned_s = 1'b1;
        endcase
    end

    assign adel_o  = valid_i & ~we_i & misaligned_s & ~exc_i;
    assign ades_o  = valid_i &  we_i & misaligned_s & ~exc_i;
    assign legal_s = valid_i & ~exc_i & ~misaligned_s & ~flush_i;

    // Byte strobes: a run of 2^size ones starting at the lane; none for loads.
    always_comb begin
        wstrb_s = {STRB_W{1'b0}};
        for (int b = 0; b < STRB_W; b++) begin
            if (we_i && (b >= lane_int_s) && (b < lane_int_s + nbytes_s)) begin
                wstrb_s[b] = 1'b1;
            end else begin
                wstrb_s[b] = 1'b0;
            end
        end
    end

    // Store data replicated across every lane group of the access size.
    always_comb begin
        wdata_rep_s = wdata_i;
        case (size_i)
            2'd0:    wdata_rep_s = {STRB_W{wdata_i[7:0]}};
            2'd1:    wdata_rep_s = {(STRB_W / 2){wdata_i[15:0]}};
            2'd2:    wdata_rep_s = {(STRB_W / 4){wdata_i[31:0]}};
            default: wdata_rep_s = wdata_i;
        endcase
    end

    // Load extraction uses the fields captured at issue, not the live inputs.
    always_comb begin
        shifted_s  = bus_rdata_i >> {lane_r, 3'b000};
        nbits_s    = int'(32'd8 << bus_size_r);
        sign_bit_s = 1'b0;
        case (bus_size_r)
            2'd0:    sign_bit_s = shifted_s[7];
            2'd1:    sign_bit_s = shifted_s[15];
            2'd2:    sign_bit_s = shifted_s[31];
            default: sign_bit_s = shifted_s[DATA_W-1];
        endcase
        load_ext_s = shifted_s;
        for (int i = 0; i < DATA_W; i++) begin
            if (i >= nbits_s) begin
                load_ext_s[i] = sext_r & sign_bit_s;
            end else begin
                load_ext_s[i] = shifted_s[i];
            end
        end
    end

    // Next-state logic. A flush after the slave accepted the request must
    // still consume the pending data_ok, hence DRAIN rather than IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (legal_s) begin
                    state_next_s = S_REQ;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (bus_addr_ok_i) begin
                    if (bus_data_ok_i) begin
                        state_next_s = flush_i ? S_IDLE : S_DONE;
                    end else begin
                        state_next_s = flush_i ? S_DRAIN : S_WAIT;
                    end
                end else if (flush_i) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (bus_data_ok_i) begin
                    state_next_s = flush_i ? S_IDLE : S_DONE;
                end else if (flush_i) begin
                    state_next_s = S_DRAIN;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_DRAIN: begin
                if (bus_data_ok_i) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_DRAIN;
                end
            end
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered request/done flags and load result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus_req_r <= 1'b0;
            done_r    <= 1'b0;
            rdata_r   <= {DATA_W{1'b0}};
        end else begin
            bus_req_r <= (state_next_s == S_REQ);
            done_r    <= (state_next_s == S_DONE);
            if ((state_next_s == S_DONE) && !bus_wr_r) begin
                rdata_r <= load_ext_s;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // Bus fields are captured once at issue and held stable while in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus_wr_r    <= 1'b0;
            bus_size_r  <= 2'd0;
            bus_addr_r  <= {ADDR_W{1'b0}};
            bus_wstrb_r <= {STRB_W{1'b0}};
            bus_wdata_r <= {DATA_W{1'b0}};
            sext_r      <= 1'b0;
            lane_r      <= {LANE_W{1'b0}};
        end else if ((state_r == S_IDLE) && legal_s) begin
            bus_wr_r    <= we_i;
            bus_size_r  <= size_i;
            bus_addr_r  <= addr_i;
            bus_wstrb_r <= wstrb_s;
            bus_wdata_r <= wdata_rep_s;
            sext_r      <= sext_i;
            lane_r      <= lane_s;
        end else begin
            bus_wr_r    <= bus_wr_r;
            bus_size_r  <= bus_size_r;
            bus_addr_r  <= bus_addr_r;
            bus_wstrb_r <= bus_wstrb_r;
            bus_wdata_r <= bus_wdata_r;
            sext_r      <= sext_r;
            lane_r      <= lane_r;
        end
    end

    // DONE releases the stall so the completing instruction advances.
    assign stall_o     = (legal_s && (state_r != S_DONE)) || (state_r == S_DRAIN);
    assign done_o      = done_r;
    assign rdata_o     = rdata_r;
    assign bus_req_o   = bus_req_r;
    assign bus_wr_o    = bus_wr_r;
    assign bus_size_o  = bus_size_r;
    assign bus_addr_o  = bus_addr_r;
    assign bus_wstrb_o = bus_wstrb_r;
    assign bus_wdata_o = bus_wdata_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: a 32-bit and a 64-bit instance share one
// stimulus driver; a bus-slave process and a completion monitor check the
// DUT against expectations queued at issue time.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel64;
    logic        valid, we, sext, exc, flush;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        addr_ok, data_ok;
    logic [63:0] rdata_bus;

    logic        stall32, done32, adel32, ades32, req32, wr32;
    logic [1:0]  size32;
    logic [31:0] addr32, rdata32, wdata32;
    logic [3:0]  wstrb32;
    logic        stall64, done64, adel64, ades64, req64, wr64;
    logic [1:0]  size64;
    logic [31:0] addr64;
    logic [63:0] rdata64, wdata64;
    logic [7:0]  wstrb64;

    always #5 clk = ~clk;

    mem_access_ctrl #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid & ~sel64), .we_i(we), .size_i(size),
        .sext_i(sext), .addr_i(addr), .wdata_i(wdata[31:0]), .exc_i(exc), .flush_i(flush),
        .stall_o(stall32), .done_o(done32), .rdata_o(rdata32), .adel_o(adel32), .ades_o(ades32),
        .bus_req_o(req32), .bus_wr_o(wr32), .bus_size_o(size32), .bus_addr_o(addr32),
        .bus_wstrb_o(wstrb32), .bus_wdata_o(wdata32),
        .bus_addr_ok_i(addr_ok & ~sel64), .bus_data_ok_i(data_ok & ~sel64),
        .bus_rdata_i(rdata_bus[31:0]));

    mem_access_ctrl #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid & sel64), .we_i(we), .size_i(size),
        .sext_i(sext), .addr_i(addr), .wdata_i(wdata), .exc_i(exc), .flush_i(flush),
        .stall_o(stall64), .done_o(done64), .rdata_o(rdata64), .adel_o(adel64), .ades_o(ades64),
        .bus_req_o(req64), .bus_wr_o(wr64), .bus_size_o(size64), .bus_addr_o(addr64),
        .bus_wstrb_o(wstrb64), .bus_wdata_o(wdata64),
        .bus_addr_ok_i(addr_ok & sel64), .bus_data_ok_i(data_ok & sel64),
        .bus_rdata_i(rdata_bus));

    // Active-DUT view.
    wire        m_stall = sel64 ? stall64 : stall32;
    wire        m_done  = sel64 ? done64  : done32;
    wire        m_adel  = sel64 ? adel64  : adel32;
    wire        m_ades  = sel64 ? ades64  : ades32;
    wire        m_req   = sel64 ? req64   : req32;
    wire        m_wr    = sel64 ? wr64    : wr32;
    wire [1:0]  m_size  = sel64 ? size64  : size32;
    wire [31:0] m_addr  = sel64 ? addr64  : addr32;
    wire [7:0]  m_wstrb = sel64 ? wstrb64 : {4'd0, wstrb32};
    wire [63:0] m_wdata = sel64 ? wdata64 : {32'd0, wdata32};
    wire [63:0] m_rdata = sel64 ? rdata64 : {32'd0, rdata32};

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [7:0]  wstrb;
        logic [63:0] wdata;
        int          a_lat;
        int          d_lat;
        logic [63:0] rdata;
    } bus_exp_t;

    bus_exp_t    bus_q[$];
    logic [63:0] done_q[$];
    logic [63:0] last_load [2];
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic logic exp_mis(input int w, input int sz, input logic [31:0] ad);
        int nb;
        nb = 1 << sz;
        if (sz == 3 && w == 32) return 1'b1;
        return (int'(ad[2:0]) % nb) != 0;
    endfunction

    function automatic logic [63:0] exp_load(input int w, input int sz, input logic sx,
                                             input int lane, input logic [63:0] rd);
        logic [63:0] v, mask, r;
        int nbits;
        nbits = 8 << sz;
        r = (w == 32) ? (rd & 64'h0000_0000_FFFF_FFFF) : rd;
        v = r >> (8 * lane);
        if (nbits < 64) begin
            mask = (64'd1 << nbits) - 64'd1;
            if (sx && v[nbits-1]) v = v | ~mask;
            else v = v & mask;
        end
        if (w == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    function automatic logic [63:0] exp_wdata(input int w, input int sz, input logic [63:0] wd);
        logic [63:0] r;
        int nb;
        nb = 1 << sz;
        r = 64'd0;
        for (int b = 0; b < w / 8; b++) r[8*b +: 8] = wd[8*(b % nb) +: 8];
        return r;
    endfunction

    task automatic push_legal(input logic we_a, input logic [1:0] sz, input logic sx,
                              input logic [31:0] ad, input logic [63:0] wd, input logic [63:0] rd,
                              input int al, input int dl, input logic expect_done);
        bus_exp_t e;
        int w, nb, lane;
        w    = sel64 ? 64 : 32;
        nb   = 1 << sz;
        lane = int'(ad[2:0]) % (w / 8);
        e.wr    = we_a;
        e.size  = sz;
        e.addr  = ad;
        e.wstrb = we_a ? 8'(((1 << nb) - 1) << lane) : 8'd0;
        e.wdata = exp_wdata(w, int'(sz), wd);
        e.a_lat = al;
        e.d_lat = dl;
        e.rdata = rd;
        bus_q.push_back(e);
        if (expect_done) begin
            if (!we_a) last_load[sel64] = exp_load(w, int'(sz), sx, lane, rd);
            done_q.push_back(last_load[sel64]);
        end
    endtask

    // Present one access at the current negedge and see it through.
    task automatic do_access(input logic we_a, input logic [1:0] sz, input logic sx,
                             input logic [31:0] ad, input logic [63:0] wd, input logic ex,
                             input logic [63:0] rd, input int al, input int dl, input string nm);
        int w, n;
        logic mis;
        w   = sel64 ? 64 : 32;
        mis = exp_mis(w, int'(sz), ad);
        valid = 1'b1; we = we_a; size = sz; sext = sx; addr = ad; wdata = wd; exc = ex;
        #1;
        if (ex || mis) begin
            chk({nm, "_adel"}, m_adel, !we_a && mis && !ex);
            chk({nm, "_ades"}, m_ades, we_a && mis && !ex);
            chk({nm, "_nostall"}, m_stall, 1'b0);
            @(posedge clk); @(negedge clk); #1;
            chk({nm, "_noreq"}, m_req, 1'b0);
        end else begin
            chk({nm, "_adel0"}, m_adel, 1'b0);
            chk({nm, "_ades0"}, m_ades, 1'b0);
            chk({nm, "_stall0"}, m_stall, 1'b1);
            push_legal(we_a, sz, sx, ad, wd, rd, al, dl, 1'b1);
            n = 0;
            while (m_stall && n < 64) begin
                @(negedge clk); #1;
                n++;
            end
            chk({nm, "_latency"}, 64'(n), 64'(2 + al + dl));
            @(posedge clk); @(negedge clk);
        end
        valid = 1'b0; exc = 1'b0;
    endtask

    // Completion monitor.
    always @(negedge clk) begin
        if (!rst && m_done) begin
            if (done_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done_spurious actual=1 expected=0 at %0t", $time);
            end else begin
                chk("rdata", m_rdata, done_q.pop_front());
            end
        end
    end

    // Bus slave: checks each request against the queued expectation and
    // answers with the queued latencies and data.
    initial begin
        bus_exp_t e;
        addr_ok = 1'b0; data_ok = 1'b0; rdata_bus = 64'd0;
        forever begin
            @(negedge clk);
            if (!rst && m_req) begin
                if (bus_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL bus_unexpected actual=1 expected=0 at %0t", $time);
                end else begin
                    e = bus_q.pop_front();
                    chk("bus_wr", m_wr, e.wr);
                    chk("bus_size", m_size, e.size);
                    chk("bus_addr", m_addr, e.addr);
                    chk("bus_wstrb", m_wstrb, e.wstrb);
                    chk("bus_wdata", m_wdata, e.wdata);
                    repeat (e.a_lat) begin
                        @(negedge clk);
                        chk("req_held", m_req, 1'b1);
                        chk("addr_held", m_addr, e.addr);
                    end
                    addr_ok = 1'b1;
                    if (e.d_lat == 0) begin
                        data_ok = 1'b1;
                        rdata_bus = e.rdata;
                    end
                    @(negedge clk);
                    addr_ok = 1'b0;
                    data_ok = 1'b0;
                    chk("req_drop", m_req, 1'b0);
                    if (e.d_lat > 0) begin
                        repeat (e.d_lat - 1) @(negedge clk);
                        data_ok = 1'b1;
                        rdata_bus = e.rdata;
                        @(negedge clk);
                        data_ok = 1'b0;
                    end
                    rdata_bus = {$urandom, $urandom};
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r_we, r_sx, r_ex;
        logic [1:0]  r_sz;
        logic [31:0] r_ad;
        sel64 = 1'b0; rst = 1'b1; valid = 1'b0; we = 1'b0; sext = 1'b0; exc = 1'b0;
        flush = 1'b0; size = 2'd0; addr = 32'd0; wdata = 64'd0;
        last_load[0] = 64'd0; last_load[1] = 64'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_req", m_req, 1'b0);
        chk("rst_done", m_done, 1'b0);
        chk("rst_stall", m_stall, 1'b0);
        chk("rst_rdata", m_rdata, 64'd0);
        chk("rst_wstrb", m_wstrb, 8'd0);
        chk("rst_addr", m_addr, 32'd0);
        chk("rst_req64", req64, 1'b0);
        chk("rst_rdata64", rdata64, 64'd0);
        @(negedge clk);

        // 32-bit directed
        do_access(1'b0, 2'd2, 1'b0, 32'h100, 64'd0, 1'b0, 64'h8899AABB, 0, 2, "lw100");
        do_access(1'b0, 2'd0, 1'b1, 32'h103, 64'd0, 1'b0, 64'h80112233, 0, 0, "lb103");
        do_access(1'b0, 2'd0, 1'b0, 32'h103, 64'd0, 1'b0, 64'h80112233, 1, 1, "lbu103");
        do_access(1'b1, 2'd1, 1'b0, 32'h102, 64'h1234, 1'b0, 64'd0, 0, 1, "sh102");
        do_access(1'b0, 2'd2, 1'b0, 32'h101, 64'd0, 1'b0, 64'd0, 0, 0, "lw101");
        do_access(1'b1, 2'd2, 1'b0, 32'h102, 64'd0, 1'b0, 64'd0, 0, 0, "sw102");
        do_access(1'b0, 2'd2, 1'b0, 32'h104, 64'd0, 1'b1, 64'd0, 0, 0, "exc");

        // Flush while waiting for data, then a load queued behind the drain.
        valid = 1'b1; we = 1'b0; size = 2'd2; sext = 1'b0; addr = 32'h200; exc = 1'b0;
        push_legal(1'b0, 2'd2, 1'b0, 32'h200, 64'd0, 64'hDEADBEEF, 0, 3, 1'b0);
        @(negedge clk); #1;
        chk("fl_req_stall", m_stall, 1'b1);
        @(negedge clk);
        valid = 1'b0; flush = 1'b1;
        #1;
        chk("fl_wait_stall", m_stall, 1'b0);
        @(negedge clk);
        flush = 1'b0; valid = 1'b1; addr = 32'h204;
        push_legal(1'b0, 2'd2, 1'b0, 32'h204, 64'd0, 64'hCAFEF00D, 0, 0, 1'b1);
        #1;
        chk("fl_drain_stall1", m_stall, 1'b1);
        chk("fl_drain_noreq1", m_req, 1'b0);
        @(negedge clk); #1;
        chk("fl_drain_stall2", m_stall, 1'b1);
        chk("fl_drain_noreq2", m_req, 1'b0);
        @(negedge clk); #1;
        chk("fl_idle_stall", m_stall, 1'b1);
        chk("fl_idle_noreq", m_req, 1'b0);
        chk("fl_nodone", m_done, 1'b0);
        @(negedge clk); #1;
        chk("fl_next_req", m_req, 1'b1);
        @(negedge clk); #1;
        chk("fl_next_done_stall", m_stall, 1'b0);
        @(posedge clk); @(negedge clk);
        valid = 1'b0;

        for (int i = 0; i < 80; i++) begin
            r_we = 1'($urandom_range(0, 1));
            r_sx = 1'($urandom_range(0, 1));
            r_sz = 2'($urandom_range(0, 3));
            r_ex = ($urandom_range(0, 7) == 0);
            r_ad = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 1) == 1) r_ad = r_ad & ~((32'd1 << r_sz) - 32'd1);
            do_access(r_we, r_sz, r_sx, r_ad, {$urandom, $urandom}, r_ex, {$urandom, $urandom},
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "rand32");
        end

        // 64-bit instance
        repeat (2) @(negedge clk);
        sel64 = 1'b1;
        do_access(1'b0, 2'd3, 1'b0, 32'h8, 64'd0, 1'b0, 64'h0123456789ABCDEF, 0, 1, "ld8");
        do_access(1'b0, 2'd3, 1'b0, 32'h4, 64'd0, 1'b0, 64'd0, 0, 0, "ld4");
        do_access(1'b1, 2'd2, 1'b0, 32'h4, 64'h89ABCDEF, 1'b0, 64'd0, 0, 0, "sw4_64");
        for (int i = 0; i < 60; i++) begin
            r_we = 1'($urandom_range(0, 1));
            r_sx = 1'($urandom_range(0, 1));
            r_sz = 2'($urandom_range(0, 3));
            r_ex = ($urandom_range(0, 7) == 0);
            r_ad = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 2) != 0) r_ad = r_ad & ~((32'd1 << r_sz) - 32'd1);
            do_access(r_we, r_sz, r_sx, r_ad, {$urandom, $urandom}, r_ex, {$urandom, $urandom},
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "rand64");
        end

        repeat (5) @(negedge clk);
        chk("bus_q_empty", 64'(bus_q.size()), 64'd0);
        chk("done_q_empty", 64'(done_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
